// File: rtl/ws2812_pkg.sv
// Shared constants and types for the WS2812 chain driver.
package ws2812_pkg;
  localparam int PIXEL_W    = 24;
  localparam int DEF_TBIT   = 125;
  localparam int DEF_T0H    = 40;
  localparam int DEF_T1H    = 80;
  localparam int DEF_TLATCH = 5000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_BIT,
    ST_LATCH
  } ws_state_t;
endpackage

// File: rtl/ws2812_chain_driver_if.sv
// Pixel write port, frame request and status bundle of the WS2812 chain driver.
interface ws2812_chain_driver_if
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8
);
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [PIXEL_W-1:0] wr_data;
  logic               start;
  logic               led;
  logic               busy;
  logic               done;
  logic               wr_err;

  modport master (output wr_en, wr_addr, wr_data, start,
                  input  led, busy, done, wr_err);
  modport slave  (input  wr_en, wr_addr, wr_data, start,
                  output led, busy, done, wr_err);
endinterface

// File: rtl/ws2812_bit_slot.sv
// One NRZ bit slot: counts TBIT cycles and drives the high part of the slot
// for T0H or T1H cycles depending on the current bit. led is registered, so it
// trails the slot counter by one cycle.
module ws2812_bit_slot
  import ws2812_pkg::*;
#(
  parameter int TBIT = DEF_TBIT,
  parameter int T0H  = DEF_T0H,
  parameter int T1H  = DEF_T1H
)(
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_bit,
  output logic o_led,
  output logic o_slot_end
);
  localparam int CW = $clog2(TBIT);
  localparam logic [CW-1:0] H0   = CW'(T0H);
  localparam logic [CW-1:0] H1   = CW'(T1H);
  localparam logic [CW-1:0] LAST = CW'(TBIT - 1);

  logic [CW-1:0] r_cnt;
  logic          r_led;

  assign o_slot_end = i_active && (r_cnt == LAST);
  assign o_led      = r_led;

  // slot counter: free-runs 0..TBIT-1 while active, parked at 0 otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (!i_active || o_slot_end) r_cnt <= '0;
    else                              r_cnt <= r_cnt + 1'b1;
  end

  // registered led so the pin never sees comparator glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_led <= 1'b0;
    else        r_led <= i_active && (r_cnt < (i_bit ? H1 : H0));
  end
endmodule

// File: rtl/ws2812_chain_driver.sv
// WS2812 chain driver: pixel buffer, frame FSM (IDLE/FETCH/BIT/LATCH),
// next-pixel prefetch and latch timing. Define WS2812_DBUF_EN for a
// double-buffered build (front/back swap on start, writes accepted while busy).
module ws2812_chain_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int TBIT     = DEF_TBIT,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int TLATCH   = DEF_TLATCH
)(
  input logic                  clk,
  input logic                  reset_n,
  ws2812_chain_driver_if.slave bus
);
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LW = $clog2(TLATCH + 1);
  localparam logic [AW-1:0] LAST_LED = AW'(NUM_LEDS - 1);

  if (!(T0H < T1H && T1H < TBIT && NUM_LEDS >= 1)) begin : g_bad_cfg
    $error("ws2812_chain_driver: need T0H < T1H < TBIT and NUM_LEDS >= 1");
  end

  ws_state_t          r_state;
  logic [PIXEL_W-1:0] r_shift;
  logic [PIXEL_W-1:0] r_next;
  logic [4:0]         r_bit_idx;
  logic [AW-1:0]      r_led_idx;
  logic [LW-1:0]      r_latch_cnt;
  logic               r_busy, r_done, r_wr_err;

  logic               w_slot_end, w_led, w_in_range, w_wr_ok, w_start_ok;
  logic [AW-1:0]      w_next_idx;
  logic [PIXEL_W-1:0] w_rd0, w_rdn;

  assign w_in_range = ({1'b0, bus.wr_addr} < (AW+1)'(NUM_LEDS));
  assign w_start_ok = (r_state == ST_IDLE) && bus.start;
  assign w_next_idx = (r_led_idx == LAST_LED) ? '0 : r_led_idx + 1'b1;

`ifdef WS2812_DBUF_EN
  logic [PIXEL_W-1:0] r_buf [2][NUM_LEDS];
  logic               r_front;

  assign w_wr_ok = bus.wr_en && w_in_range;
  assign w_rd0   = r_buf[r_front][0];
  assign w_rdn   = r_buf[r_front][w_next_idx];

  // writes always land in the back buffer; the swap below makes a write that
  // coincides with start part of the new frame
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_buf[~r_front][bus.wr_addr] <= bus.wr_data;
  end

  // front pointer is part of buffer storage, so reset leaves it alone
  always_ff @(posedge clk) begin
    if (reset_n && w_start_ok) r_front <= ~r_front;
  end
`else
  logic [PIXEL_W-1:0] r_buf [NUM_LEDS];

  assign w_wr_ok = bus.wr_en && w_in_range && (r_state == ST_IDLE);
  assign w_rd0   = r_buf[0];
  assign w_rdn   = r_buf[w_next_idx];

  // single buffer: only written while idle, so a frame always sees stable data
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_buf[bus.wr_addr] <= bus.wr_data;
  end
`endif

  ws2812_bit_slot #(.TBIT(TBIT), .T0H(T0H), .T1H(T1H)) u_slot (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_active   (r_state == ST_BIT),
    .i_bit      (r_shift[PIXEL_W-1]),
    .o_led      (w_led),
    .o_slot_end (w_slot_end)
  );

  // frame FSM; the latch counter runs TLATCH+1 states because led lags the
  // slot counter by one cycle, giving exactly TLATCH low cycles on the pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_next      <= '0;
      r_bit_idx   <= '0;
      r_led_idx   <= '0;
      r_latch_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_wr_err <= bus.wr_en && !w_wr_ok;
      r_next   <= w_rdn;
      case (r_state)
        ST_IDLE: if (w_start_ok) begin
          r_state <= ST_FETCH;
          r_busy  <= 1'b1;
        end
        ST_FETCH: begin
          r_shift   <= w_rd0;
          r_bit_idx <= 5'd23;
          r_led_idx <= '0;
          r_state   <= ST_BIT;
        end
        ST_BIT: if (w_slot_end) begin
          if (r_bit_idx != 5'd0) begin
            r_bit_idx <= r_bit_idx - 1'b1;
            r_shift   <= {r_shift[PIXEL_W-2:0], 1'b0};
          end else if (r_led_idx == LAST_LED) begin
            r_state     <= ST_LATCH;
            r_latch_cnt <= '0;
          end else begin
            r_shift   <= r_next;
            r_bit_idx <= 5'd23;
            r_led_idx <= r_led_idx + 1'b1;
          end
        end
        ST_LATCH: begin
          if (r_latch_cnt == LW'(TLATCH)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_latch_cnt <= r_latch_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.led    = w_led;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.wr_err = r_wr_err;
endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Self-checking bench for ws2812_chain_driver: a frame-level waveform model
// checked every cycle, plus literal pulse-width / latency pins.
module tb_ws2812_chain_driver;
  localparam int N      = 3;
  localparam int AW     = 2;
  localparam int TBIT   = 20;
  localparam int T0H    = 6;
  localparam int T1H    = 13;
  localparam int TLATCH = 150;
  localparam int NB     = N * 24 * TBIT;
  localparam int DONE_T = 2 + NB + TLATCH;
  localparam int LOGN   = 32768;
`ifdef WS2812_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ws2812_chain_driver_if #(.NUM_LEDS(N)) bus();

  ws2812_chain_driver #(.NUM_LEDS(N), .TBIT(TBIT), .T0H(T0H), .T1H(T1H),
                        .TLATCH(TLATCH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cyc = -1;
  bit led_log [LOGN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] m_front [N];
  logic [23:0] m_back  [N];
  logic [23:0] m_tmp   [N];
  logic [23:0] m_frame [N];
  int m_k = 0;
  bit m_active = 0;
  bit exp_led, exp_busy, exp_done, exp_err;

  // at each edge: apply writes/start by the rules, then derive the pin values
  // from the frame snapshot and the elapsed cycles since acceptance
  always @(posedge clk) begin
    bit busy_before;
    int t, s, slot;
    logic [23:0] px;
    cyc++;
    if (!reset_n) begin
      m_active = 0;
      {exp_led, exp_busy, exp_done, exp_err} = '0;
    end else begin
      busy_before = m_active && (cyc - m_k) <= DONE_T;
      exp_err = 0;
      if (bus.wr_en) begin
        if (bus.wr_addr < N && (DBUF || !busy_before)) m_back[bus.wr_addr] = bus.wr_data;
        else exp_err = 1;
      end
      if (bus.start && !busy_before) begin
        m_k = cyc;
        m_active = 1;
        if (DBUF) begin
          m_tmp = m_front; m_front = m_back; m_back = m_tmp;
          m_frame = m_front;
        end else begin
          m_frame = m_back;
        end
      end
      t = cyc - m_k;
      s = t - 2;
      exp_busy = m_active && t < DONE_T;
      exp_done = m_active && t == DONE_T;
      exp_led  = 0;
      if (m_active && s >= 0 && s < NB) begin
        slot = s / TBIT;
        px = m_frame[slot / 24];
        exp_led = (s % TBIT) < (px[23 - slot % 24] ? T1H : T0H);
      end
    end
  end

  // compare and log on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (cyc < LOGN) led_log[cyc] = bus.led;
    if (bus.done) done_cyc = cyc;
    if (!reset_n) begin
      chk("rst_led", bus.led, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_wr_err", bus.wr_err, 0);
    end else begin
      chk("led", bus.led, exp_led);
      chk("busy", bus.busy, exp_busy);
      chk("done", bus.done, exp_done);
      chk("wr_err", bus.wr_err, exp_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wr(input int a, input logic [23:0] d);
    bus.wr_en = 1; bus.wr_addr = AW'(a); bus.wr_data = d;
    tick();
    bus.wr_en = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < DONE_T + 50) begin tick(); n++; end
    n_tests++;
    if (bus.busy) begin n_fail++; $display("FAIL %s: still busy after %0d cycles", name, n); end
    tick();
  endtask

  function automatic int run_len(input int from);
    int n = 0;
    while (from + n < LOGN && led_log[from + n]) n++;
    return n;
  endfunction

  function automatic int first_one(input int from);
    for (int i = from; i < LOGN; i++) if (led_log[i]) return i;
    return -1;
  endfunction

  task automatic frame_rand(input bit hold);
    int n = 0;
    for (int a = 0; a < N; a++) wr(a, 24'($urandom));
    bus.start = 1;
    repeat ($urandom_range(1, 3)) tick();
    bus.start = hold;
    while (bus.busy && n < DONE_T + 50) begin
      bus.wr_en = ($urandom_range(0, 99) < 2);
      bus.wr_addr = AW'($urandom_range(0, 3));
      bus.wr_data = 24'($urandom);
      bus.start = hold | ($urandom_range(0, 199) == 0);
      tick(); n++;
    end
    bus.wr_en = 0;
    bus.start = hold;
    n_tests++;
    if (bus.busy) begin n_fail++; $display("FAIL rand_frame: still busy after %0d cycles", n); end
    tick();
    if (hold) begin
      bus.start = 0;
      chk("b2b_accept", bus.busy, 1);
      wait_idle("b2b_frame");
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int k, rise, cnt;
    reset_n = 0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 0;
    repeat (3) tick();
    reset_n = 1;
    tick();

    // frame with a 1 in the first and last bit of pixel 0
    wr(0, 24'h800001); wr(1, 24'h0); wr(2, 24'h0);
    bus.start = 1; tick(); bus.start = 0;
    k = cyc; done_cyc = -1;
    chk("busy_at_accept", bus.busy, 1);
    wait_idle("frame1");
    rise = first_one(k);
    chk("start_to_rise", rise - k, 2);
    chk("slot0_high", run_len(rise), 13);
    chk("slot1_high", run_len(rise + TBIT), 6);
    chk("slot23_high", run_len(rise + 23 * TBIT), 13);
    chk("slot24_high", run_len(rise + 24 * TBIT), 6);
    cnt = 0;
    for (int i = rise; i < rise + 1590; i++) cnt += int'(led_log[i]);
    chk("frame_high_total", cnt, 446);     // 2*13 + 70*6
    chk("rise_to_done", done_cyc - rise, 1590); // 72*20 + 150

    // out-of-range write
    bus.wr_en = 1; bus.wr_addr = 2'd3; bus.wr_data = 24'h5A5A5A; tick(); bus.wr_en = 0;
    chk("wr_err_oor", bus.wr_err, 1);
    tick();
    chk("wr_err_one_cycle", bus.wr_err, 0);

    // write coinciding with start, then a write while busy
    wr(1, 24'h0); wr(2, 24'h0);
    bus.wr_en = 1; bus.wr_addr = 2'd0; bus.wr_data = 24'hFFFFFF; bus.start = 1;
    tick();
    bus.wr_en = 0; bus.start = 0; k = cyc;
    repeat (5) tick();
    bus.wr_en = 1; bus.wr_addr = 2'd1; bus.wr_data = 24'h123456; tick(); bus.wr_en = 0;
    chk("wr_err_busy", bus.wr_err, DBUF ? 0 : 1);
    wait_idle("frame_simul");
    rise = first_one(k);
    cnt = 0;
    for (int i = 0; i < 24; i++) if (run_len(rise + i * TBIT) == 13) cnt++;
    chk("simul_ones_slots", cnt, 24);

    // reset in the middle of slot 10, then replay
    bus.start = 1; tick(); bus.start = 0; k = cyc;
    while (cyc < k + 2 + 10 * TBIT + 3) tick();
    chk("pre_reset_led", bus.led, 1);
    reset_n = 0; #1;
    chk("mid_reset_led", bus.led, 0);
    chk("mid_reset_busy", bus.busy, 0);
    done_cyc = -1;
    repeat (3) tick();
    reset_n = 1;
    tick();
    chk("no_done_after_reset", done_cyc, -1);
    bus.start = 1; tick(); bus.start = 0;
    wait_idle("replay");

    // randomized frames, one with start held across done
    for (int f = 0; f < 3; f++) frame_rand(f == 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
